// File: rtl/motor_cmd_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : motor_cmd_scheduler_if
//  Description : Request and drive bundle between the motion requesters
//                (line follower, aux task, estop) and the motor command
//                scheduler that feeds the H-bridge PWM drivers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface motor_cmd_scheduler_if;
    logic        estop;
    logic [3:0]  lf_direction;
    logic [11:0] lf_duty_a;
    logic [11:0] lf_duty_b;
    logic        aux_req;
    logic [3:0]  aux_direction;
    logic [11:0] aux_duty_a;
    logic [11:0] aux_duty_b;
    logic        aux_grant;
    logic [3:0]  Direction;
    logic [11:0] DutyA;
    logic [11:0] DutyB;
    logic        dead_busy;
    logic        dir_err;

    // Requester side: issues requests, observes the drive outputs
    modport master (
        output estop, lf_direction, lf_duty_a, lf_duty_b,
               aux_req, aux_direction, aux_duty_a, aux_duty_b,
        input  aux_grant, Direction, DutyA, DutyB, dead_busy, dir_err
    );

    // Scheduler side
    modport slave (
        input  estop, lf_direction, lf_duty_a, lf_duty_b,
               aux_req, aux_direction, aux_duty_a, aux_duty_b,
        output aux_grant, Direction, DutyA, DutyB, dead_busy, dir_err
    );
endinterface
`default_nettype wire

// File: rtl/motor_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : motor_cmd_scheduler
//  Description : Arbitrates line-follower / aux motion requests (estop has
//                priority), inserts a zero-drive dead time on every
//                direction change and ramps duty increases.
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_cmd_scheduler #(
    parameter int DEAD_CYCLES = 1000,
    parameter int RAMP_DIV    = 5000,
    parameter int RAMP_STEP   = 250,
    parameter int DUTY_MAX    = 4000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    motor_cmd_scheduler_if.slave bus
);

    localparam int                 c_CNT_W     = $clog2(DEAD_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_DEAD_LOAD = c_CNT_W'(DEAD_CYCLES - 1);
    localparam int                 c_PRE_W     = $clog2(RAMP_DIV + 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(RAMP_DIV - 1);
    localparam logic [11:0]        c_DUTY_MAX  = 12'(DUTY_MAX);
    localparam logic [12:0]        c_STEP      = 13'(RAMP_STEP);

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_LF   = 2'd1;
    localparam logic [1:0] c_OWN_AUX  = 2'd2;

    localparam logic [0:0] c_ST_STOPPED = 1'b0;
    localparam logic [0:0] c_ST_RUN     = 1'b1;

    logic [1:0]         r_owner;
    logic [c_PRE_W-1:0] r_pre;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         r_direction;
    logic [3:0]         w_dir_nxt;
    logic [11:0]        r_duty_a;
    logic [11:0]        r_duty_b;
    logic [11:0]        w_duty_a_nxt;
    logic [11:0]        w_duty_b_nxt;

    logic [3:0]         w_sel_dir;
    logic [11:0]        w_sel_a;
    logic [11:0]        w_sel_b;
    logic               w_dir_err;
    logic [3:0]         w_tgt_dir;
    logic [11:0]        w_tgt_a;
    logic [11:0]        w_tgt_b;
    logic               w_tick;

    function automatic logic f_legal(input logic [3:0] d);
        case (d)
            4'b0000, 4'b0110, 4'b1001, 4'b0101, 4'b1010: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    // Decreases land immediately; increases advance one step per ramp tick
    // without overshooting the target (13-bit sum cannot wrap).
    function automatic logic [11:0] f_duty_step(input logic [11:0] cur,
                                                input logic [11:0] tgt,
                                                input logic        tick);
        logic [12:0] sum;
        sum = {1'b0, cur} + c_STEP;
        if (cur > tgt)
            return tgt;
        else if (cur < tgt && tick)
            return (sum > {1'b0, tgt}) ? tgt : sum[11:0];
        else
            return cur;
    endfunction

    assign w_tick = (r_pre == c_PRE_LAST);

    // Ownership register: estop clears ownership, aux outranks the line follower
    always_ff @(posedge clk) begin
        if (reset)
            r_owner <= c_OWN_NONE;
        else if (bus.estop)
            r_owner <= c_OWN_NONE;
        else if (bus.aux_req)
            r_owner <= c_OWN_AUX;
        else
            r_owner <= c_OWN_LF;
    end

    // Free-running ramp prescaler, independent of the drive state
    always_ff @(posedge clk) begin
        if (reset)
            r_pre <= '0;
        else if (w_tick)
            r_pre <= '0;
        else
            r_pre <= r_pre + 1'b1;
    end

    // Target selection from the registered owner, sanitised and clamped
    always_comb begin
        w_sel_dir = 4'd0;
        w_sel_a   = 12'd0;
        w_sel_b   = 12'd0;
        case (r_owner)
            c_OWN_LF: begin
                w_sel_dir = bus.lf_direction;
                w_sel_a   = bus.lf_duty_a;
                w_sel_b   = bus.lf_duty_b;
            end
            c_OWN_AUX: begin
                w_sel_dir = bus.aux_direction;
                w_sel_a   = bus.aux_duty_a;
                w_sel_b   = bus.aux_duty_b;
            end
            default: ;
        endcase
        w_dir_err = ~f_legal(w_sel_dir);
        w_tgt_dir = w_dir_err ? 4'd0 : w_sel_dir;
        if (w_tgt_dir == 4'd0) begin
            w_tgt_a = 12'd0;
            w_tgt_b = 12'd0;
        end else begin
            w_tgt_a = (w_sel_a > c_DUTY_MAX) ? c_DUTY_MAX : w_sel_a;
            w_tgt_b = (w_sel_b > c_DUTY_MAX) ? c_DUTY_MAX : w_sel_b;
        end
    end

    // Drive state register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_ST_STOPPED;
        else
            r_state <= w_state_nxt;
    end

    // Next-state: estop always lands in STOPPED; a direction mismatch in RUN
    // goes back through the dead time
    always_comb begin
        w_state_nxt = r_state;
        if (bus.estop) begin
            w_state_nxt = c_ST_STOPPED;
        end else begin
            case (r_state)
                c_ST_STOPPED:
                    if (r_cnt == '0 && w_tgt_dir != 4'd0)
                        w_state_nxt = c_ST_RUN;
                c_ST_RUN:
                    if (w_tgt_dir != r_direction)
                        w_state_nxt = c_ST_STOPPED;
                default:
                    w_state_nxt = c_ST_STOPPED;
            endcase
        end
    end

    // Next drive outputs and dead counter; the counter is never restarted
    // while it runs, so the latest target is taken at expiry
    always_comb begin
        w_dir_nxt    = r_direction;
        w_duty_a_nxt = r_duty_a;
        w_duty_b_nxt = r_duty_b;
        w_cnt_nxt    = r_cnt;
        if (bus.estop) begin
            w_dir_nxt    = 4'd0;
            w_duty_a_nxt = 12'd0;
            w_duty_b_nxt = 12'd0;
            w_cnt_nxt    = c_DEAD_LOAD;
        end else begin
            case (r_state)
                c_ST_STOPPED: begin
                    w_dir_nxt    = 4'd0;
                    w_duty_a_nxt = 12'd0;
                    w_duty_b_nxt = 12'd0;
                    w_cnt_nxt    = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                    if (r_cnt == '0 && w_tgt_dir != 4'd0)
                        w_dir_nxt = w_tgt_dir;
                end
                c_ST_RUN: begin
                    if (w_tgt_dir != r_direction) begin
                        w_dir_nxt    = 4'd0;
                        w_duty_a_nxt = 12'd0;
                        w_duty_b_nxt = 12'd0;
                        w_cnt_nxt    = c_DEAD_LOAD;
                    end else begin
                        w_duty_a_nxt = f_duty_step(r_duty_a, w_tgt_a, w_tick);
                        w_duty_b_nxt = f_duty_step(r_duty_b, w_tgt_b, w_tick);
                    end
                end
                default: begin
                    w_dir_nxt    = 4'd0;
                    w_duty_a_nxt = 12'd0;
                    w_duty_b_nxt = 12'd0;
                end
            endcase
        end
    end

    // Drive output and dead counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_direction <= 4'd0;
            r_duty_a    <= 12'd0;
            r_duty_b    <= 12'd0;
            r_cnt       <= '0;
        end else begin
            r_direction <= w_dir_nxt;
            r_duty_a    <= w_duty_a_nxt;
            r_duty_b    <= w_duty_b_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign bus.aux_grant = (r_owner == c_OWN_AUX);
    assign bus.Direction = r_direction;
    assign bus.DutyA     = r_duty_a;
    assign bus.DutyB     = r_duty_b;
    assign bus.dead_busy = (r_state == c_ST_STOPPED) && (r_cnt != '0);
    assign bus.dir_err   = w_dir_err;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_cmd_scheduler
//  Description : Directed self-checking bench for motor_cmd_scheduler with
//                DEAD_CYCLES=4, RAMP_DIV=2, RAMP_STEP=1000, DUTY_MAX=4000.
//                Edge numbers in comments count clock edges after reset
//                release; ramp ticks land on even edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_cmd_scheduler;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    motor_cmd_scheduler_if bus ();

    motor_cmd_scheduler #(
        .DEAD_CYCLES (4),
        .RAMP_DIV    (2),
        .RAMP_STEP   (1000),
        .DUTY_MAX    (4000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic set_lf(input logic [3:0] d, input logic [11:0] a, input logic [11:0] b);
        bus.lf_direction = d;
        bus.lf_duty_a    = a;
        bus.lf_duty_b    = b;
    endtask

    // Directed sequence
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.estop         = 1'b0;
        bus.aux_req       = 1'b0;
        bus.aux_direction = 4'd0;
        bus.aux_duty_a    = 12'd0;
        bus.aux_duty_b    = 12'd0;
        set_lf(4'd0, 12'd0, 12'd0);
        step(2);

        check("rst_dir",   16'(bus.Direction), 16'd0);
        check("rst_duty_a", 16'(bus.DutyA),    16'd0);
        check("rst_duty_b", 16'(bus.DutyB),    16'd0);
        check("rst_grant", 16'(bus.aux_grant), 16'd0);
        check("rst_busy",  16'(bus.dead_busy), 16'd0);
        check("rst_err",   16'(bus.dir_err),   16'd0);

        // Start-up: forward, full duty
        reset = 1'b0;
        set_lf(4'b0110, 12'd4000, 12'd4000);
        step(1);                                        // e1: owner becomes LF
        check("start_dir_e1", 16'(bus.Direction), 16'd0);
        step(1);                                        // e2
        check("start_dir_e2", 16'(bus.Direction), 16'b0110);
        check("start_a_e2",   16'(bus.DutyA),     16'd0);
        step(1);                                        // e3: no tick
        check("start_a_e3",   16'(bus.DutyA),     16'd0);
        step(1);                                        // e4
        check("ramp_a_1000",  16'(bus.DutyA),     16'd1000);
        step(2);                                        // e6
        check("ramp_a_2000",  16'(bus.DutyA),     16'd2000);
        check("ramp_b_2000",  16'(bus.DutyB),     16'd2000);
        step(2);                                        // e8
        check("ramp_a_3000",  16'(bus.DutyA),     16'd3000);
        step(2);                                        // e10
        check("ramp_a_4000",  16'(bus.DutyA),     16'd4000);
        check("ramp_b_4000",  16'(bus.DutyB),     16'd4000);

        // Reverse: dead time of exactly 4 zero cycles
        set_lf(4'b1001, 12'd3000, 12'd3000);
        step(1);                                        // e11
        check("rev_dir_e11",  16'(bus.Direction), 16'd0);
        check("rev_a_e11",    16'(bus.DutyA),     16'd0);
        check("rev_busy_e11", 16'(bus.dead_busy), 16'd1);
        step(3);                                        // e14
        check("rev_dir_e14",  16'(bus.Direction), 16'd0);
        check("rev_busy_e14", 16'(bus.dead_busy), 16'd0);
        step(1);                                        // e15
        check("rev_dir_e15",  16'(bus.Direction), 16'b1001);
        check("rev_a_e15",    16'(bus.DutyA),     16'd0);
        step(1);                                        // e16
        check("rev_a_e16",    16'(bus.DutyA),     16'd1000);
        step(4);                                        // e20
        check("rev_a_e20",    16'(bus.DutyA),     16'd3000);

        // Back to forward at 4000, then drop duty with same direction
        set_lf(4'b0110, 12'd4000, 12'd4000);
        step(4);                                        // e24
        check("fwd_dir_e24",  16'(bus.Direction), 16'd0);
        step(1);                                        // e25
        check("fwd_dir_e25",  16'(bus.Direction), 16'b0110);
        step(7);                                        // e32
        check("fwd_a_e32",    16'(bus.DutyA),     16'd4000);
        set_lf(4'b0110, 12'd1500, 12'd1500);
        step(1);                                        // e33
        check("drop_a",       16'(bus.DutyA),     16'd1500);
        check("drop_b",       16'(bus.DutyB),     16'd1500);
        check("drop_dir",     16'(bus.Direction), 16'b0110);
        check("drop_busy",    16'(bus.dead_busy), 16'd0);

        // Aux takes over with a different direction
        bus.aux_req       = 1'b1;
        bus.aux_direction = 4'b0101;
        bus.aux_duty_a    = 12'd3000;
        bus.aux_duty_b    = 12'd3000;
        step(1);                                        // e34
        check("aux_grant_e34", 16'(bus.aux_grant), 16'd1);
        check("aux_dir_e34",   16'(bus.Direction), 16'b0110);
        step(1);                                        // e35
        check("aux_dir_e35",   16'(bus.Direction), 16'd0);
        check("aux_busy_e35",  16'(bus.dead_busy), 16'd1);
        step(3);                                        // e38
        check("aux_dir_e38",   16'(bus.Direction), 16'd0);
        step(1);                                        // e39
        check("aux_dir_e39",   16'(bus.Direction), 16'b0101);
        bus.aux_req = 1'b0;
        step(1);                                        // e40: tick, owner back to LF
        check("aux_grant_e40", 16'(bus.aux_grant), 16'd0);
        check("aux_a_e40",     16'(bus.DutyA),     16'd1000);
        step(1);                                        // e41
        check("lf_dir_e41",    16'(bus.Direction), 16'd0);
        step(3);                                        // e44
        check("lf_dir_e44",    16'(bus.Direction), 16'd0);
        step(1);                                        // e45
        check("lf_dir_e45",    16'(bus.Direction), 16'b0110);
        step(3);                                        // e48
        check("lf_a_e48",      16'(bus.DutyA),     16'd1500);

        // Estop mid-ramp, with aux_req asserted at the same time
        set_lf(4'b0110, 12'd4000, 12'd4000);
        step(2);                                        // e50
        check("pre_estop_a",   16'(bus.DutyA),     16'd2500);
        bus.estop   = 1'b1;
        bus.aux_req = 1'b1;
        step(1);                                        // e51
        check("estop_dir",     16'(bus.Direction), 16'd0);
        check("estop_a",       16'(bus.DutyA),     16'd0);
        check("estop_b",       16'(bus.DutyB),     16'd0);
        check("estop_grant",   16'(bus.aux_grant), 16'd0);
        check("estop_busy",    16'(bus.dead_busy), 16'd1);
        step(9);                                        // e60: 10 edges under estop
        check("estop_hold_dir",   16'(bus.Direction), 16'd0);
        check("estop_hold_grant", 16'(bus.aux_grant), 16'd0);
        check("estop_hold_busy",  16'(bus.dead_busy), 16'd1);
        bus.estop   = 1'b0;
        bus.aux_req = 1'b0;
        step(3);                                        // e63
        check("rel_dir_e63",   16'(bus.Direction), 16'd0);
        check("rel_busy_e63",  16'(bus.dead_busy), 16'd0);
        step(1);                                        // e64
        check("rel_dir_e64",   16'(bus.Direction), 16'b0110);
        check("rel_a_e64",     16'(bus.DutyA),     16'd0);
        step(2);                                        // e66
        check("rel_a_e66",     16'(bus.DutyA),     16'd1000);

        // Illegal direction code
        set_lf(4'b1111, 12'd4000, 12'd4000);
        step(1);                                        // e67
        check("ill_err",       16'(bus.dir_err),   16'd1);
        check("ill_dir",       16'(bus.Direction), 16'd0);
        check("ill_a",         16'(bus.DutyA),     16'd0);

        // Over-range duty is clamped
        set_lf(4'b0110, 12'd4095, 12'd4095);
        step(1);                                        // e68
        check("clr_err",       16'(bus.dir_err),   16'd0);
        step(3);                                        // e71
        check("clamp_dir",     16'(bus.Direction), 16'b0110);
        step(9);                                        // e80
        check("clamp_a",       16'(bus.DutyA),     16'd4000);
        check("clamp_b",       16'(bus.DutyB),     16'd4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_cmd_scheduler.md
Name: motor_cmd_scheduler

Overview:
- Sits between the rover's motion requesters and the H-bridge PWM drivers.
- Arbitrates between two Direction/Duty requesters: the line follower (lf) and an auxiliary manoeuvre task (aux: servo/IR routines, recovery moves). Emergency stop (estop) takes priority over both.
- Enforces a zero-drive dead time on every direction change, so the H-bridge never reverses under load.
- Ramps duty increases; duty decreases are applied immediately.

Parameters:
DEAD_CYCLES, 1000, number of cycles Direction is held at 4'b0000 (duties 0) before a new nonzero direction is applied; must be ≥1
RAMP_DIV, 5000, clk cycles per ramp tick
RAMP_STEP, 250, duty increment per ramp tick
DUTY_MAX, 4000, clamp applied to every requested duty

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
estop  in  1  level; forces stop while high
lf_direction  in  4  line-follower direction request
lf_duty_a  in  12  line-follower duty A request
lf_duty_b  in  12  line-follower duty B request
aux_req  in  1  level; aux requests ownership of motors
aux_direction  in  4  aux direction request
aux_duty_a  in  12  aux duty A request
aux_duty_b  in  12  aux duty B request
aux_grant  out  1  registered; aux currently owns motors
Direction  out  4  H-bridge direction to drivers
DutyA  out  12  PWM duty A to drivers
DutyB  out  12  PWM duty B to drivers
dead_busy  out  1  high while in STOPPED with counter nonzero
dir_err  out  1  one-cycle pulse when the selected request carries an illegal direction code

Behaviour:
- Reset values: Direction=0, DutyA=DutyB=0, aux_grant=0, dead_busy=0, dir_err=0, state=STOPPED, dead counter=0, ramp prescaler=0.
- Owner register, updated every cycle: estop→NONE; else aux_req→AUX; else LF. aux_grant=(owner==AUX), so it rises 1 cycle after aux_req.
- Target is taken from the registered owner. For owner NONE, target = dir 0, duties 0.
- Target duties are clamped to DUTY_MAX.
- Legal direction codes: 0000 stop, 0110 fwd, 1001 bwd, 0101 left, 1010 right.
- An illegal code is treated as target 0000 with duties 0, and dir_err pulses for each cycle it is selected.
- Target dir 0000 forces target duties to 0.
- State STOPPED:
  - Outputs Direction=0, duties=0.
  - Dead counter decrements each cycle and saturates at 0.
  - When counter==0 and target dir≠0: Direction←target dir, duties stay 0, go to RUN.
  - Exactly DEAD_CYCLES cycles of Direction=0 follow any zeroing edge.
  - If the target changes during the count, the counter does not restart; the latest target is applied at expiry.
- State RUN:
  - If target dir≠Direction (including to 0000): Direction←0, DutyA=DutyB←0, counter←DEAD_CYCLES-1, go to STOPPED; all on the same edge.
  - Otherwise, for each duty independently:
    - duty>target: duty←target on the next edge (immediate, no tick needed).
    - duty<target, on a ramp tick: duty←min(duty+RAMP_STEP, target). Compute in 13 bits; no wrap.
- Ramp prescaler:
  - Free-running 0..RAMP_DIV-1; tick when it equals RAMP_DIV-1.
  - Not reset by state changes.
- estop:
  - From any state, on the next edge: Direction=0, duties=0, counter←DEAD_CYCLES-1, state=STOPPED, owner=NONE.
  - Held estop reloads the counter every cycle.
  - The dead time therefore runs fully after estop release.
- Ownership change with the same direction (e.g. lf and aux both 0110) does not trigger dead time; duties simply move toward the new target.
- reset overrides estop and everything else.
- Simultaneous estop and aux_req: estop wins, aux_grant=0.

Test Plan:
- Params DEAD_CYCLES=4, RAMP_DIV=2, RAMP_STEP=1000. Reset, then lf 0110/4000/4000 → Direction=0110 once counter=0; duties 0→1000→2000→3000→4000, stepping on each tick.
- In RUN at 0110/4000, lf changes to 1001/3000 → next edge Direction=0, duties 0; exactly 4 cycles of 0; then Direction=1001; duty ramps to 3000.
- lf 0110 at duty 4000, lf drops duty to 1500 with the same direction → DutyA=DutyB=1500 on the next edge, no dead time, dead_busy stays 0.
- lf 0110, assert aux_req with aux 0101/3000 → aux_grant=1 after 1 cycle; dead-time sequence follows. Drop aux_req → owner LF; 0110 restored after dead time.
- estop mid-ramp → outputs 0 on the next edge. Hold 10 cycles, release → Direction stays 0 for 4 cycles after release, then re-ramps from 0.
- lf_direction=1111 → dir_err pulses each selected cycle; outputs go to stop. Request duty 4095 → clamped to 4000.
